// File: rtl/laser_pkg.sv
// Shared types and helpers for the LaserReceiver -> FT232H byte-pair writer.
package laser_pkg;

  typedef struct packed {
    logic [7:0] d1;
    logic [7:0] d2;
  } byte_pair_t;

  typedef enum logic [2:0] {IDLE, WAIT, SETUP, STROBE, HOLD} wr_state_t;

  localparam int PAIR_W = $bits(byte_pair_t);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // sel=0 selects the laser-1 byte, which always goes out first.
  function automatic logic [7:0] pair_byte(input byte_pair_t p, input logic sel);
    return sel ? p.d2 : p.d1;
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous DEPTH-entry FIFO with a sticky overflow flag for dropped pushes.
module pair_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;
  logic             do_push;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/laser_rx_ftdi_writer.sv
// Buffers LaserReceiver byte pairs and writes them to an FT232H over the async
// 245-FIFO interface, with WR# setup/strobe/hold timed in system clock cycles.
module laser_rx_ftdi_writer
  import laser_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   data_valid,
  input  logic [7:0]             data1_in,
  input  logic [7:0]             data2_in,
  input  logic                   ftdi_txe_n,
  output logic                   ftdi_wr_n,
  output logic [7:0]             ftdi_data,
  output logic                   ftdi_oe,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   busy
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);

  // Stage p0/p1: rising-edge detect and capture of the pair seen at the edge
  logic       valid_p0;
  logic       push_p1;
  byte_pair_t capt_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_p0 <= 1'b0;
      push_p1  <= 1'b0;
    end else begin
      valid_p0 <= data_valid;
      push_p1  <= data_valid & ~valid_p0;
    end
  end

  always_ff @(posedge clock) begin
    if (data_valid && !valid_p0) capt_p1 <= {data1_in, data2_in};
  end

  // TXE# is asynchronous to CLOCK_50; idle-high reset keeps the writer parked.
  logic txe_sync_p0;
  logic txe_sync_p1;
  logic txe_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      txe_sync_p0 <= 1'b1;
      txe_sync_p1 <= 1'b1;
    end else begin
      txe_sync_p0 <= ftdi_txe_n;
      txe_sync_p1 <= txe_sync_p0;
    end
  end

  assign txe_ok = ~txe_sync_p1;

  logic       pop;
  logic       empty;
  logic       unused_full;
  byte_pair_t head;

  pair_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(PAIR_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_p1),
    .push_data (capt_p1),
    .pop       (pop),
    .pop_data  (head),
    .full      (unused_full),
    .empty     (empty),
    .count     (fifo_count),
    .overflow  (overflow)
  );

  // Stage p2: write FSM holding the popped pair
  wr_state_t  state;
  wr_state_t  state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic       sel;
  logic       sel_next;
  byte_pair_t pair_p2;
  byte_pair_t pair_next;
  logic [7:0] data_next;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sel_next   = sel;
    pair_next  = pair_p2;
    data_next  = ftdi_data;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          pair_next  = head;
          sel_next   = 1'b0;
          data_next  = pair_byte(head, 1'b0);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (txe_ok) begin
          cnt_next   = '0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (!txe_ok) begin
          state_next = WAIT;
        end else if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          cnt_next   = '0;
          state_next = STROBE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt == CNT_W'(STROBE_CYC - 1)) begin
          cnt_next   = '0;
          state_next = HOLD;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          cnt_next = '0;
          if (!sel) begin
            sel_next   = 1'b1;
            data_next  = pair_byte(pair_p2, 1'b1);
            state_next = WAIT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so WR# comes straight off a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      ftdi_wr_n <= 1'b1;
      ftdi_oe   <= 1'b0;
      ftdi_data <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      sel       <= sel_next;
      ftdi_wr_n <= (state_next != STROBE);
      ftdi_oe   <= (state_next != IDLE);
      ftdi_data <= data_next;
    end
  end

  always_ff @(posedge clock) begin
    pair_p2 <= pair_next;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_laser_rx_ftdi_writer.sv
// Directed bench: an expected-byte queue is matched against every completed WR# strobe.
module tb_laser_rx_ftdi_writer;

  localparam int DEPTH      = 16;
  localparam int SETUP_CYC  = 1;
  localparam int STROBE_CYC = 2;
  localparam int HOLD_CYC   = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       data_valid = 1'b0;
  logic [7:0] data1_in = '0;
  logic [7:0] data2_in = '0;
  logic       ftdi_txe_n = 1'b0;
  logic       ftdi_wr_n;
  logic [7:0] ftdi_data;
  logic       ftdi_oe;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       overflow;
  logic       busy;

  always #5 clock = ~clock;

  laser_rx_ftdi_writer #(
    .DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_valid (data_valid),
    .data1_in   (data1_in),
    .data2_in   (data2_in),
    .ftdi_txe_n (ftdi_txe_n),
    .ftdi_wr_n  (ftdi_wr_n),
    .ftdi_data  (ftdi_data),
    .ftdi_oe    (ftdi_oe),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  int n_cmp  = 0;
  int n_bad  = 0;
  int nbytes = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Byte-level model: each WR# low period is one written byte, in queue order.
  bit         prev_wr    = 1'b1;
  int         low_len    = 0;
  int         hold_left  = 0;
  int         stable_len = 0;
  logic [7:0] last_data  = '0;
  logic [7:0] strobe_byte = '0;
  logic [7:0] held_byte  = '0;

  always @(negedge clock) begin
    if (reset) begin
      prev_wr    = 1'b1;
      low_len    = 0;
      hold_left  = 0;
      stable_len = 0;
    end else begin
      if (ftdi_oe && stable_len > 0 && ftdi_data == last_data) stable_len++;
      else stable_len = ftdi_oe ? 1 : 0;
      if (!ftdi_wr_n) begin
        check("oe_in_strobe", ftdi_oe, 1);
        if (prev_wr) begin
          check("setup_cycles", (stable_len - 1 >= SETUP_CYC), 1);
          strobe_byte = ftdi_data;
        end else begin
          check("data_in_strobe", ftdi_data, strobe_byte);
        end
        low_len++;
      end else if (!prev_wr) begin
        check("strobe_len", low_len, STROBE_CYC);
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("write_byte", strobe_byte, exp_q.pop_front());
        nbytes++;
        low_len   = 0;
        hold_left = HOLD_CYC;
        held_byte = strobe_byte;
      end
      if (hold_left > 0) begin
        check("hold_data", ftdi_data, held_byte);
        check("hold_oe", ftdi_oe, 1);
        hold_left--;
      end
      prev_wr   = ftdi_wr_n;
      last_data = ftdi_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [7:0] d1, input logic [7:0] d2, input bit expect_out);
    data1_in   = d1;
    data2_in   = d2;
    data_valid = 1'b1;
    if (expect_out) begin
      exp_q.push_back(d1);
      exp_q.push_back(d2);
    end
    tick(1);
    data_valid = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick(1);
      if (!busy && fifo_count == 0 && exp_q.size() == 0) done = 1'b1;
    end
    check({name, "_idle_timeout"}, done, 1);
  endtask

  task automatic wait_wr_rise(input string name);
    bit seen_low = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick(1);
      if (!ftdi_wr_n) seen_low = 1'b1;
      else if (seen_low) done = 1'b1;
    end
    check({name, "_rise_timeout"}, done, 1);
  endtask

  initial begin
    int base;
    bit got_low;

    // Reset state
    tick(2);
    check("rst_wr_n", ftdi_wr_n, 1);
    check("rst_oe", ftdi_oe, 0);
    check("rst_data", ftdi_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick(4);

    // 1: single pair, literal cycle-by-cycle expectations
    base = nbytes;
    data1_in = 8'h12; data2_in = 8'h34; data_valid = 1'b1;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    tick(1);
    data_valid = 1'b0;
    tick(1);
    check("t1_count_after_push", fifo_count, 1);
    tick(1);
    check("t1_oe_wait", ftdi_oe, 1);
    check("t1_data_byte1", ftdi_data, 8'h12);
    check("t1_count_after_pop", fifo_count, 0);
    check("t1_wr_n_wait", ftdi_wr_n, 1);
    tick(2);
    check("t1_wr_n_strobe", ftdi_wr_n, 0);
    tick(2);
    check("t1_wr_n_hold", ftdi_wr_n, 1);
    check("t1_data_hold", ftdi_data, 8'h12);
    tick(1);
    check("t1_data_byte2", ftdi_data, 8'h34);
    wait_idle("t1", 100);
    check("t1_bytes", nbytes - base, 2);
    check("t1_oe_idle", ftdi_oe, 0);

    // 2: level held high pushes once
    base = nbytes;
    data1_in = 8'hC8; data2_in = 8'h77; data_valid = 1'b1;
    exp_q.push_back(8'hC8); exp_q.push_back(8'h77);
    tick(20);
    data_valid = 1'b0;
    wait_idle("t2", 100);
    check("t2_bytes", nbytes - base, 2);

    // 3: TXE# high; the head pair sits in the writer, 16 fill the FIFO, the next is dropped
    base = nbytes;
    ftdi_txe_n = 1'b1;
    tick(3);
    for (int i = 0; i < 18; i++) pulse(8'h40 + 8'(i), 8'hA0 + 8'(i), i < 17);
    tick(1);
    check("t3_count_full", fifo_count, 16);
    check("t3_overflow", overflow, 1);
    check("t3_busy", busy, 1);
    check("t3_wr_n_blocked", ftdi_wr_n, 1);
    check("t3_head_byte", ftdi_data, 8'h40);
    ftdi_txe_n = 1'b0;
    wait_idle("t3", 600);
    check("t3_bytes", nbytes - base, 34);
    check("t3_overflow_sticky", overflow, 1);

    // 4: TXE# goes high right as byte 2 enters SETUP
    base = nbytes;
    pulse(8'hA5, 8'h5A, 1'b1);
    wait_wr_rise("t4_byte1");
    ftdi_txe_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t4_wr_n_held", ftdi_wr_n, 1);
      check("t4_data_kept", ftdi_data, 8'h5A);
    end
    ftdi_txe_n = 1'b0;
    wait_idle("t4", 100);
    check("t4_bytes", nbytes - base, 2);

    // 5: reset lands during STROBE
    base = nbytes;
    pulse(8'h11, 8'h22, 1'b0);
    pulse(8'h33, 8'h44, 1'b0);
    got_low = 1'b0;
    for (int i = 0; i < 50 && !got_low; i++) begin
      if (!ftdi_wr_n) got_low = 1'b1;
      else tick(1);
    end
    check("t5_strobe_timeout", got_low, 1);
    check("t5_count_pre", fifo_count, 1);
    check("t5_overflow_pre", overflow, 1);
    reset = 1'b1;
    tick(1);
    check("t5_wr_n", ftdi_wr_n, 1);
    check("t5_oe", ftdi_oe, 0);
    check("t5_count", fifo_count, 0);
    check("t5_overflow", overflow, 0);
    check("t5_busy", busy, 0);
    tick(1);
    reset = 1'b0;
    tick(40);
    check("t5_no_write", nbytes - base, 0);
    check("t5_busy_after", busy, 0);

    // 6: push coincides with the pop of a full FIFO
    base = nbytes;
    ftdi_txe_n = 1'b1;
    tick(3);
    for (int i = 0; i < 17; i++) pulse(8'h60 + 8'(i), 8'hD0 + 8'(i), 1'b1);
    tick(1);
    check("t6_count_full", fifo_count, 16);
    ftdi_txe_n = 1'b0;
    wait_wr_rise("t6_byte1");
    wait_wr_rise("t6_byte2");
    data1_in = 8'hEE; data2_in = 8'hFF; data_valid = 1'b1;
    exp_q.push_back(8'hEE); exp_q.push_back(8'hFF);
    tick(1);
    data_valid = 1'b0;
    tick(1);
    check("t6_count_same", fifo_count, 16);
    check("t6_overflow", overflow, 0);
    wait_idle("t6", 600);
    check("t6_bytes", nbytes - base, 36);
    check("t6_overflow_end", overflow, 0);

    check("leftover_bytes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
